// File: rtl/alu_issue_stage_if.sv
// ID-to-EX handshake and ALU operand/control bundle for alu_issue_stage.
// The master side drives id_* and the EX back-pressure; the slave is the stage.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic            ex_stall;
  logic            flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_inp_A;
  logic [XLEN-1:0] ex_inp_B;
  logic [2:0]      ex_sel;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            illegal;

  modport master (
    output id_valid, id_instr, id_pc,
    output id_rs1_data, id_rs2_data,
    output ex_stall, flush,
    input  id_ready, ex_valid,
    input  ex_inp_A, ex_inp_B, ex_sel,
    input  ex_rs2_data, ex_rd,
    input  ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_branch,
    input  ex_pc, ex_imm, illegal
  );

  modport slave (
    input  id_valid, id_instr, id_pc,
    input  id_rs1_data, id_rs2_data,
    input  ex_stall, flush,
    output id_ready, ex_valid,
    output ex_inp_A, ex_inp_B, ex_sel,
    output ex_rs2_data, ex_rd,
    output ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_branch,
    output ex_pc, ex_imm, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX register: RV32I-subset decode into ALU select and immediates,
// load-use bubble insertion, downstream stall and flush handling.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_stage_if.slave bus
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_SLT = 3'b100;
  localparam logic [2:0] SEL_BRC = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [2:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
  } ex_t;

  logic [0:0] state;
  ex_t        ex_q;
  ex_t        ex_d;
  logic       illegal_q;

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic is_r, is_i, is_lw, is_sw, is_beq;
  logic legal, uses_rs2, wr;
  logic hazard, run_haz;

  assign ins    = bus.id_instr;
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign rd     = ins[11:7];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];

  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}},
                  ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){ins[31]}}, ins[31],
                  ins[7], ins[30:25], ins[11:8], 1'b0};

  assign is_r   = opcode == 7'b0110011;
  assign is_i   = opcode == 7'b0010011;
  assign is_lw  = opcode == 7'b0000011;
  assign is_sw  = opcode == 7'b0100011;
  assign is_beq = opcode == 7'b1100011;

  always_comb begin
    ex_d     = '0;
    legal    = 1'b0;
    uses_rs2 = 1'b0;
    wr       = 1'b0;
    unique case (1'b1)
      is_r: begin
        uses_rs2 = 1'b1;
        wr       = 1'b1;
        legal    = 1'b1;
        ex_d.b   = bus.id_rs2_data;
        unique case (f3)
          3'b000:  ex_d.sel = ins[30] ? SEL_SUB : SEL_ADD;
          3'b111:  ex_d.sel = SEL_AND;
          3'b110:  ex_d.sel = SEL_OR;
          3'b010:  ex_d.sel = SEL_SLT;
          default: legal = 1'b0;
        endcase
      end
      is_i: begin
        wr       = 1'b1;
        legal    = 1'b1;
        ex_d.b   = imm_i;
        ex_d.imm = imm_i;
        unique case (f3)
          3'b000:  ex_d.sel = SEL_ADD;
          3'b111:  ex_d.sel = SEL_AND;
          3'b110:  ex_d.sel = SEL_OR;
          3'b010:  ex_d.sel = SEL_SLT;
          default: legal = 1'b0;
        endcase
      end
      is_lw: begin
        legal         = f3 == 3'b010;
        wr            = 1'b1;
        ex_d.b        = imm_i;
        ex_d.imm      = imm_i;
        ex_d.mem_read = 1'b1;
      end
      is_sw: begin
        legal          = f3 == 3'b010;
        uses_rs2       = 1'b1;
        ex_d.b         = imm_s;
        ex_d.imm       = imm_s;
        ex_d.mem_write = 1'b1;
      end
      is_beq: begin
        legal       = f3 == 3'b000;
        uses_rs2    = 1'b1;
        ex_d.sel    = SEL_BRC;
        ex_d.b      = bus.id_rs2_data;
        ex_d.imm    = imm_b;
        ex_d.branch = 1'b1;
      end
      default: ;
    endcase
    if (legal) begin
      ex_d.valid     = 1'b1;
      ex_d.a         = bus.id_rs1_data;
      ex_d.rs2       = bus.id_rs2_data;
      ex_d.pc        = bus.id_pc;
      ex_d.reg_write = wr & (rd != 5'd0);
      ex_d.rd        = ex_d.reg_write ? rd : 5'd0;
    end else begin
      ex_d = '0;
    end
  end

  // x0 never forwards a load result, so ex_rd == 0 cannot cause a stall
  assign hazard = ex_q.valid & ex_q.mem_read
                & (ex_q.rd != 5'd0)
                & ((ex_q.rd == rs1)
                 | ((ex_q.rd == rs2) & uses_rs2));
  assign run_haz = (state == RUN) & hazard;

  assign bus.id_ready = rst_n & ~bus.ex_stall
                      & ~bus.flush & ~run_haz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
      state     <= RUN;
    end else if (bus.flush) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
      state     <= RUN;
    end else if (bus.ex_stall) begin
      illegal_q <= 1'b0;
    end else if (run_haz && bus.id_valid) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
      state     <= BUBBLE;
    end else begin
      ex_q      <= bus.id_valid ? ex_d : '0;
      illegal_q <= bus.id_valid & ~legal;
      state     <= RUN;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_sel       = ex_q.sel;
  assign bus.ex_inp_A     = ex_q.a;
  assign bus.ex_inp_B     = ex_q.b;
  assign bus.ex_rs2_data  = ex_q.rs2;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_branch    = ex_q.branch;
  assign bus.illegal      = illegal_q;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX boundary register of the five-stage core. It drives the ALU's operand and select inputs (inp_A, inp_B, 3-bit sel) and sits between the register-file read in ID and the ALU in EX. The block decodes the supported RV32I subset into the ALU select encoding and sign-extended immediates, and registers operands and control for EX. It also inserts load-use bubbles and handles downstream stall and flush.

## Interface
- XLEN, 32, operand/PC width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_ready  out  1  instruction accepted this cycle (combinational)
- id_instr  in  32  raw instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register operands, already forwarded
- ex_stall  in  1  EX cannot advance; hold all outputs
- flush  in  1  kill instruction in ID and EX (branch taken)
- ex_valid  out  1  registered outputs hold a real instruction
- ex_inp_A, ex_inp_B  out  XLEN  ALU operands
- ex_sel  out  3  ALU select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 branch-compare SUB
- ex_rs2_data  out  XLEN  store data
- ex_rd  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  control
- ex_pc  out  XLEN  registered PC
- ex_imm  out  XLEN  registered immediate, used for branch target
- illegal  out  1  one-cycle pulse: unsupported opcode accepted

## Operation
- **Decode** (opcode, funct3, funct7[5]):
  - R-type 0110011: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 010 SLT.
  - I-type 0010011: 000 ADD, 111 AND, 110 OR, 010 SLT; B = I-imm.
  - 0000011 funct3 010 (LW): ADD, B = I-imm, mem_read, reg_write.
  - 0100011 funct3 010 (SW): ADD, B = S-imm, mem_write, no reg_write.
  - 1100011 funct3 000 (BEQ): sel 101, B = rs2, branch, imm = B-imm.
  - Anything else: illegal. It is accepted, issued as a bubble, and raises the illegal pulse.
- **Immediates**: sign-extended from instr[31] to XLEN. B-imm bit 0 = 0.
- A = rs1_data in all cases. ex_rd is forced to 0 and reg_write cleared when rd = 0.
- **Bubble**: ex_valid = 0, all control = 0, ex_sel = 000, data fields don't-care (implementation drives 0).
- **State machine**, states RUN and BUBBLE:
  - Load-use hazard = ex_valid & ex_mem_read & ex_rd ≠ 0 & (ex_rd == rs1 | (ex_rd == rs2 & opcode uses rs2)).
  - RUN, id_valid, no stall, hazard: load bubble, id_ready = 0, go to BUBBLE.
  - BUBBLE: hazard check suppressed; the next non-stalled cycle accepts the held instruction, then return to RUN.
- **Priority**: rst_n > flush > ex_stall > hazard > normal issue.

## Timing
- **Latency**: instruction accepted on edge N appears on ex_* after edge N (one cycle).
- **id_ready** = ~ex_stall & ~flush & ~(state == RUN & hazard). Upstream holds id_* while id_valid & ~id_ready.
- **ex_stall = 1**: every ex_* register and the state hold, and illegal is 0.
- **flush = 1**: next edge loads a bubble regardless of stall, returns state to RUN, and accepts nothing.
- **Reset**, while rst_n = 0 at an edge:
  - All outputs go to 0, state goes to RUN, illegal goes to 0.
  - id_ready is 0 during reset.
  - Reset mid-bubble discards the pending instruction.
- illegal asserts for exactly the cycle after acceptance. It is cleared by stall or flush.
- Back-to-back loads to the same rd: only the dependent consumer bubbles; a load→load chain with no dependency issues every cycle.

## Test plan
- **Reset then ADD**: rst_n low 2 cycles, then `add x3,x1,x2` with rs1 = 5, rs2 = 7 → next cycle ex_valid = 1, ex_sel = 000, A = 5, B = 7, ex_rd = 3, reg_write = 1.
- **SUB/AND/OR/SLT/ADDI**: `addi x4,x1,-1` → ex_sel = 000, B = 0xFFFFFFFF; `sub` → 001; `ori` imm 0x0F0 → 011, B = 0x000000F0.
- **Load-use**:
  - `lw x5,4(x1)` then `add x6,x5,x2` → cycle after LW: ex_valid = 0, id_ready was 0.
  - The following cycle: ex_valid = 1 with add.
  - `lw x0` then dependent: no bubble.
- **Stall hold**: ex_stall high 3 cycles during `beq` (sel 101, B-imm −8 = 0xFFFFFFF8) → outputs constant, id_ready = 0. Release → next instruction issues.
- **Flush priority**: flush and ex_stall together while BUBBLE pending → next edge ex_valid = 0, state RUN, held instruction not issued.
- **Illegal**: opcode 1101111 → ex_valid = 0, illegal = 1 for one cycle, id_ready = 1.
